// File: rtl/user_out_arbiter.sv
// Round-robin arbiter that merges NUM_REQ vld/ack streams into one registered, source-tagged stream.
// Optional statistics counters (stat_beats, stat_stall) are built when ARB_STATS_EN is defined.
module user_out_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned REQ_BITS     = 2,
  parameter int unsigned PAYLOAD_BITS = 32,
  parameter int unsigned MAX_BURST    = 16
) (
  input  logic                            clk_user,
  input  logic                            reset_n,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         out_data,
  output logic [REQ_BITS-1:0]             out_src,
  output logic                            out_vld,
  input  logic                            out_ack,
  output logic                            busy
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]                     stat_beats,
  output logic [31:0]                     stat_stall
`endif
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                  state_q, state_d;
  logic [REQ_BITS-1:0]     ptr_q, ptr_d;
  logic [REQ_BITS-1:0]     gnt_q, gnt_d;
  logic [7:0]              burst_q, burst_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic [REQ_BITS-1:0]     src_q, src_d;
  logic                    vld_q, vld_d;
  logic                    busy_q, busy_d;

  logic                    can_load;
  logic                    gnt_vld;
  logic                    accept;
  logic [7:0]              burst_inc;
  logic                    found;
  logic [REQ_BITS-1:0]     pick;
  logic [REQ_BITS-1:0]     idx;

  assign can_load  = !vld_q || out_ack;
  assign gnt_vld   = req_vld[gnt_q];
  assign accept    = (state_q == StGrant) && gnt_vld && can_load;
  assign burst_inc = (burst_q == 8'(MAX_BURST)) ? burst_q : burst_q + 8'd1;

  always_comb begin
    req_ack = '0;
    if (accept) req_ack[gnt_q] = 1'b1;
  end

  // First valid requester after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      idx = REQ_BITS'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    burst_d = burst_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = pick;
          burst_d = 8'd0;
        end
      end
      StGrant: begin
        if (accept) burst_d = burst_inc;
        // A stalled output never releases; only a vld drop or a capped burst does.
        if (!gnt_vld || (accept && burst_inc == 8'(MAX_BURST))) begin
          state_d = StIdle;
          ptr_d   = gnt_q;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StGrant);
  end

  always_comb begin
    data_d = data_q;
    src_d  = src_q;
    vld_d  = vld_q;
    if (accept) begin
      data_d = req_data[gnt_q*PAYLOAD_BITS +: PAYLOAD_BITS];
      src_d  = gnt_q;
      vld_d  = 1'b1;
    end else if (out_ack) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= REQ_BITS'(NUM_REQ - 1);
      gnt_q   <= '0;
      burst_q <= 8'd0;
      data_q  <= '0;
      src_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
      data_q  <= data_d;
      src_q   <= src_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign out_data = data_q;
  assign out_src  = src_q;
  assign out_vld  = vld_q;
  assign busy     = busy_q;

`ifdef ARB_STATS_EN
  logic [31:0] beats_q, beats_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    beats_d = accept ? beats_q + 32'd1 : beats_q;
    stall_d = stall_q;
    if (vld_q && !out_ack && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_user or negedge reset_n) begin
    if (!reset_n) begin
      beats_q <= 32'd0;
      stall_q <= 32'd0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end

  assign stat_beats = beats_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_user_out_arbiter.sv
// Scoreboard bench for user_out_arbiter: directed requester traffic, expected beats queued up front,
// a negedge monitor pops and compares every transferred output beat.
module tb_user_out_arbiter;
  localparam int NR = 4;
  localparam int PB = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*PB-1:0] req_data;
  logic [NR-1:0]   req_vld;
  logic [NR-1:0]   req_ack;
  logic [PB-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_vld;
  logic            out_ack;
  logic            busy;
`ifdef ARB_STATS_EN
  logic [31:0]     stat_beats;
  logic [31:0]     stat_stall;
`endif

  always #5 clk = ~clk;

  user_out_arbiter #(
    .NUM_REQ(NR), .REQ_BITS(2), .PAYLOAD_BITS(PB), .MAX_BURST(16)
  ) dut (
    .clk_user(clk),
    .reset_n (rst_n),
    .req_data(req_data),
    .req_vld (req_vld),
    .req_ack (req_ack),
    .out_data(out_data),
    .out_src (out_src),
    .out_vld (out_vld),
    .out_ack (out_ack),
    .busy    (busy)
`ifdef ARB_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_stall(stat_stall)
`endif
  );

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int nbeats = 0;
  int cnt[NR];   // beats each requester still has to offer
  int seq[NR];   // driver-side sequence number per requester
  int sseq[NR];  // scoreboard-side sequence number per requester

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_run(input int src, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.src  = 2'(src);
      b.data = {8'(src), 24'(sseq[src])};
      exp_q.push_back(b);
      sseq[src]++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int w = 0;
    while (nbeats < target && w < budget) begin
      tick();
      w++;
    end
    total++;
    if (nbeats < target) begin
      bad++;
      $display("FAIL wait_beats: got %0d beats want %0d", nbeats, target);
    end
  endtask

  // Requester driver: inputs change #1 after the edge, acks sampled on the negedge.
  initial begin
    logic [NR-1:0] acked;
    req_vld  = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      acked = req_vld & req_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acked[i] && cnt[i] > 0) begin
          cnt[i]--;
          seq[i]++;
        end
        req_vld[i] = (cnt[i] > 0);
        req_data[i*PB +: PB] = {8'(i), 24'(seq[i])};
      end
    end
  end

  // Monitor: a beat leaves the DUT on the coming edge when out_vld && out_ack.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && out_vld && out_ack) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got src=%0d data=%0h want none", out_src, out_data);
        end else begin
          b = exp_q.pop_front();
          check("beat_src", 64'(out_src), 64'(b.src));
          check("beat_data", 64'(out_data), 64'(b.data));
        end
        nbeats++;
      end
    end
  end

  initial begin
    int base;
    int s0;
    out_ack = 1'b1;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 1;
      seq[i] = 0;
      sseq[i] = 0;
    end

    // Reset with every requester valid.
    repeat (3) tick();
    check("rst_req_ack", 64'(req_ack), 64'd0);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    push_run(0, 1); push_run(1, 1); push_run(2, 1); push_run(3, 1);
    rst_n = 1'b1;
    tick();
    check("first_grant_ack", 64'(req_ack), 64'b0001);
    check("first_grant_busy", 64'(busy), 64'd1);
    wait_beats(4, 40);

    // Round robin, two beats each.
    base = nbeats;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 2;
      push_run(i, 2);
    end
    wait_beats(base + 8, 80);

    // Burst cap: alternating runs of 16, tail of 8.
    base = nbeats;
    cnt[1] = 40;
    cnt[2] = 40;
    push_run(1, 16); push_run(2, 16); push_run(1, 16); push_run(2, 16);
    push_run(1, 8);  push_run(2, 8);
    wait_beats(base + 80, 300);

    // Backpressure mid-burst.
    base = nbeats;
    s0 = sseq[0];
    cnt[0] = 6;
    push_run(0, 6);
    wait_beats(base + 2, 40);
    out_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_req_ack", 64'(req_ack), 64'd0);
      check("bp_out_vld", 64'(out_vld), 64'd1);
      check("bp_out_data", 64'(out_data), 64'({8'd0, 24'(s0 + 2)}));
    end
    check("bp_busy", 64'(busy), 64'd1);
    out_ack = 1'b1;
    wait_beats(base + 6, 40);

    // Vld drop and wrap from index 3.
    base = nbeats;
    cnt[3] = 3;
    cnt[0] = 2;
    push_run(3, 3); push_run(0, 2); push_run(3, 2);
    wait_beats(base + 4, 60);
    cnt[3] = 2;
    wait_beats(base + 7, 60);

    // Reset mid-burst drops the held beat.
    base = nbeats;
    cnt[1] = 10;
    push_run(1, 10);
    wait_beats(base + 3, 40);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_vld", 64'(out_vld), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_req_ack", 64'(req_ack), 64'd0);
`ifdef ARB_STATS_EN
    check("mid_rst_stat_beats", 64'(stat_beats), 64'd0);
`endif
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    exp_q.delete();
    tick();
    tick();
    for (int i = 0; i < NR; i++) sseq[i] = seq[i];
    rst_n = 1'b1;

    // Five beats with two stall cycles.
    base = nbeats;
    cnt[2] = 5;
    push_run(2, 5);
    wait_beats(base + 2, 40);
    out_ack = 1'b0;
    tick();
    tick();
    out_ack = 1'b1;
    wait_beats(base + 5, 40);
    repeat (3) tick();
`ifdef ARB_STATS_EN
    check("stat_beats", 64'(stat_beats), 64'd5);
    check("stat_stall", 64'(stat_stall), 64'd2);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("end_out_vld", 64'(out_vld), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
